// File: rtl/key_inv_expand.sv
// Inverse AES-128 key schedule: walks from the round-10 key back to the cipher key,
// one round key per handshake. Optional INVKEY_ZEROIZE_EN clears the key after round 0.
module key_inv_expand #(
  parameter int NROUNDS = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [127:0]       key_last_i,
  output logic [127:0]       key_round_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               sub_req_o,
  output logic [31:0]        sub_word_o,
  input  logic               sub_ack_i,
  input  logic [31:0]        sub_word_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  // Handshakes: a round key transfers on a clock edge where valid_o && ready_i;
  // a substitution completes on an edge where sub_req_o && sub_ack_i. Request-side
  // outputs hold stable until their transfer edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [127:0]         key_q, key_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 done_q, done_d;
  logic [31:0]          w3_new;
  logic [31:0]          rot_word;

  function automatic logic [7:0] rcon_of(input logic [ROUND_W-1:0] r);
    case (int'(r))
      1:       rcon_of = 8'h01;
      2:       rcon_of = 8'h02;
      3:       rcon_of = 8'h04;
      4:       rcon_of = 8'h08;
      5:       rcon_of = 8'h10;
      6:       rcon_of = 8'h20;
      7:       rcon_of = 8'h40;
      8:       rcon_of = 8'h80;
      9:       rcon_of = 8'h1b;
      10:      rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // w3 of the previous round is recovered first; its RotWord feeds the S-box.
  assign w3_new   = key_q[63:32] ^ key_q[31:0];
  assign rot_word = {w3_new[23:0], w3_new[31:24]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = key_last_i;
          round_d = ROUND_W'(NROUNDS);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ready_i) begin
          if (round_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef INVKEY_ZEROIZE_EN
            key_d   = '0;
`else
            key_d   = key_q;
`endif
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (sub_ack_i) begin
          key_d   = {key_q[127:96] ^ sub_word_i ^ {rcon_of(round_q), 24'h0},
                     key_q[127:96] ^ key_q[95:64],
                     key_q[95:64] ^ key_q[63:32],
                     w3_new};
          round_d = round_q - ROUND_W'(1);
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_o     = (state_q == EMIT);
  assign key_round_o = valid_o ? key_q : '0;
  assign round_o     = round_q;
  assign sub_req_o   = (state_q == SUB);
  assign sub_word_o  = sub_req_o ? rot_word : '0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_key_inv_expand.sv
// Directed bench for key_inv_expand: expected round keys come from a forward
// AES-128 key expansion of the cipher key and are checked in reverse order.
module tb_key_inv_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic         ack_en = 1'b0;
  logic [127:0] key_last = '0;
  logic [127:0] key_round;
  logic [3:0]   round;
  logic         valid;
  logic         sub_req;
  logic [31:0]  sub_word_req;
  logic [31:0]  sub_word_rsp;
  logic         sub_ack;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic [131:0] exp_q[$];
  logic [31:0]  fw [44];
  logic         first_seen = 1'b0;
  logic [31:0]  first_sub = '0;
  logic [127:0] k9 = '0;
  logic [127:0] k0 = '0;

  logic [2047:0] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_bits[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] key_of(input int r);
    return {fw[4*r], fw[4*r+1], fw[4*r+2], fw[4*r+3]};
  endfunction

  always #5 clk = ~clk;

  // External S-box unit model: answers in the same cycle as the request.
  assign sub_word_rsp = sub_word(sub_word_req);
  assign sub_ack      = ack_en;

  key_inv_expand #(.NROUNDS(10), .ROUND_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_last_i(key_last),
    .key_round_o(key_round), .round_o(round), .valid_o(valid), .ready_i(ready),
    .sub_req_o(sub_req), .sub_word_o(sub_word_req), .sub_ack_i(sub_ack),
    .sub_word_i(sub_word_rsp), .busy_o(busy), .done_o(done), .state_o(state)
  );

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe on the falling edge, then advance past the next rising edge.
  task automatic cycle();
    logic [131:0] e;
    @(negedge clk);
    if (valid && ready) begin
      chk("sb_nonempty", 132'(exp_q.size() != 0), 132'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("key_out", {round, key_round}, e);
      if (round == 4'd9) k9 = key_round;
      if (round == 4'd0) k0 = key_round;
    end
    if (!valid) chk("key_zero", key_round, '0);
    if (sub_req) begin
      if (round == 4'd0) chk("sub_round", round, 4'd1);
      else chk("sub_word", sub_word_req,
               {fw[4*int'(round)-1][23:0], fw[4*int'(round)-1][31:24]});
      if (!first_seen) begin
        first_seen = 1'b1;
        first_sub  = sub_word_req;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_walk();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), key_of(r)});
    key_last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    start    = 1'b1;
    cyc      = 0;
    done_cnt = 0;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("walk_done", 132'(done_cnt), 132'd1);
  endtask

  initial begin
    logic [127:0] ck;
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] snap_key;
    logic [31:0]  snap_sub;
    int bp, dl, n;
    logic sp;

    // Forward key expansion of the FIPS-197 A.1 cipher key.
    ck = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) fw[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = fw[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      fw[i] = fw[i-4] ^ tmp;
    end

    // Reset state.
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sub_req", sub_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_round", round, 4'd0);
    chk("rst_sub_word", sub_word_req, 32'd0);
    chk("rst_state", state, 2'd0);
    rst = 1'b0;
    cycle();

    // Full walk, ready and ack always high.
    ready  = 1'b1;
    ack_en = 1'b1;
    start_walk();
    run_to_done(60);
    chk("done_cycle", 132'(done_cyc), 132'd22);
    chk("first_sub", first_sub, 32'h5c006e57);
    chk("round9_key", k9, 128'hac7766f319fadc2128d12941575c006e);
    chk("round0_key", k0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("sb_drained", 132'(exp_q.size()), 132'd0);
    cycle();
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
`ifdef INVKEY_ZEROIZE_EN
    chk("key_probe", dut.key_q, 128'h0);
`else
    chk("key_probe", dut.key_q, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif

    // Back-pressure at round 7, delayed ack at round 5, spurious start at round 3.
    bp = 0;
    dl = 0;
    sp = 1'b0;
    n  = 0;
    snap_key = '0;
    snap_sub = '0;
    start_walk();
    while (done_cnt == 0 && n < 120) begin
      ready  = 1'b1;
      ack_en = 1'b1;
      start  = 1'b0;
      if (valid && round == 4'd7 && bp < 5) begin
        ready = 1'b0;
        if (bp == 0) snap_key = key_round;
        else begin
          chk("bp_key_stable", key_round, snap_key);
          chk("bp_round", round, 4'd7);
          chk("bp_no_sub", sub_req, 1'b0);
        end
        bp++;
      end
      if (sub_req && round == 4'd5 && dl < 3) begin
        ack_en = 1'b0;
        if (dl == 0) snap_sub = sub_word_req;
        else begin
          chk("dl_sub_held", sub_word_req, snap_sub);
          chk("dl_valid", valid, 1'b0);
          chk("dl_key_zero", key_round, '0);
        end
        dl++;
      end
      if (valid && round == 4'd3 && !sp) begin
        start    = 1'b1;
        key_last = ~key_last;
        sp       = 1'b1;
      end
      cycle();
      n++;
    end
    start = 1'b0;
    chk("walk2_done", 132'(done_cnt), 132'd1);
    chk("bp_cycles", 132'(bp), 132'd5);
    chk("dl_cycles", 132'(dl), 132'd3);
    chk("sb2_drained", 132'(exp_q.size()), 132'd0);
    cycle();

    // Reset in the middle of a walk at round 4.
    ready  = 1'b1;
    ack_en = 1'b1;
    start_walk();
    n = 0;
    while (!(valid && round == 4'd4) && n < 40) begin
      cycle();
      n++;
    end
    chk("reach_r4", {valid, round}, {1'b1, 4'd4});
    ready = 1'b0;
    rst   = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sub_req", sub_req, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("mid_rst_no_done", 132'(done_cnt), 132'd0);
    chk("mid_rst_idle", valid, 1'b0);

    // Start in the same cycle as reset: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    key_last = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    cycle();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 1'b0);
    cycle();
    chk("rst_start_valid", valid, 1'b0);

    // Fresh walk after the abort starts again from round 10.
    start_walk();
    chk("fresh_round10", {valid, round}, {1'b1, 4'd10});
    run_to_done(60);
    chk("fresh_done_cycle", 132'(done_cyc), 132'd22);
    chk("sb3_drained", 132'(exp_q.size()), 132'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
